// File: rtl/lram_line_fill.sv
// Ping-pong line RAM owner: fetches one scanline from VRAM into the half the display just left,
// while serving display reads from the other half, and flags lines that were not filled in time.
// state | meaning
// IDLE  | no fill pending; display reads only
// FETCH | one outstanding VRAM request per cycle until cnt pixels have been written
module lram_line_fill #(
  parameter int AW    = 20,
  parameter int DEPTH = 1024
) (
  input  logic          gclk,
  input  logic          rst,
  input  logic          HCOMP,
  input  logic          VCOMP,
  input  logic          LRAMSEL,
  input  logic [9:0]    LRAMADR,
  output logic [15:0]   LRAMDAT,
  input  logic          fill_en,
  input  logic [9:0]    fetch_line,
  input  logic [9:0]    xscroll,
  input  logic [10:0]   hpix,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_ack,
  input  logic [15:0]   rd_data,
  output logic          busy,
  output logic          overrun,
  output logic [7:0]    ovr_cnt
);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t      state, state_nxt;
  logic        fill_half;
  logic [9:0]  line_r;
  logic [9:0]  xs_r;
  logic [10:0] cnt;
  logic [9:0]  x;
  logic [9:0]  col;
  logic        last;
  logic        wr_en;

  logic [15:0] ram [0:2*DEPTH-1];

  assign col     = xs_r + x;
  assign rd_addr = AW'({line_r, col});
  assign rd_req  = (state == FETCH);
  assign busy    = (state == FETCH);
  assign last    = (({1'b0, x} + 11'd1) == cnt);
  assign wr_en   = (state == FETCH) && rd_ack && !rst;

  always_ff @(posedge gclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (HCOMP)
      state_nxt = (fill_en && (hpix != 11'd0)) ? FETCH : IDLE;
    else if ((state == FETCH) && rd_ack && last)
      state_nxt = IDLE;
  end

  // A new line start always wins over the ack of the same cycle: the ack still lands in the old half.
  always_ff @(posedge gclk) begin
    if (rst) begin
      fill_half <= 1'b0;
      line_r    <= '0;
      xs_r      <= '0;
      cnt       <= '0;
      x         <= '0;
    end else if (HCOMP) begin
      fill_half <= LRAMSEL;
      line_r    <= fetch_line;
      xs_r      <= xscroll;
      cnt       <= hpix;
      x         <= '0;
    end else if ((state == FETCH) && rd_ack && !last) begin
      x <= x + 10'd1;
    end
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      overrun <= 1'b0;
      ovr_cnt <= '0;
    end else if (HCOMP && (state == FETCH)) begin
      overrun <= 1'b1;
      if (VCOMP)                 ovr_cnt <= 8'd1;
      else if (ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
    end else if (VCOMP) begin
      ovr_cnt <= '0;
    end
  end

  always_ff @(posedge gclk) begin
    if (wr_en) ram[{fill_half, x}] <= rd_data;
  end

  always_ff @(posedge gclk) begin
    if (rst) LRAMDAT <= '0;
    else     LRAMDAT <= ram[{LRAMSEL, LRAMADR}];
  end

endmodule

// File: tb/tb_lram_line_fill.sv
// Directed bench for lram_line_fill: fills, wait states, wrap, overrun, idle fills, display reads, reset.
module tb_lram_line_fill;

  logic        gclk = 1'b0;
  logic        rst, HCOMP, VCOMP, LRAMSEL, fill_en, rd_ack;
  logic [9:0]  LRAMADR, fetch_line, xscroll;
  logic [10:0] hpix;
  logic [15:0] rd_data, LRAMDAT;
  logic        rd_req, busy, overrun;
  logic [19:0] rd_addr;
  logic [7:0]  ovr_cnt;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_ram [0:2047];

  lram_line_fill #(.AW(20), .DEPTH(1024)) dut (
    .gclk(gclk), .rst(rst), .HCOMP(HCOMP), .VCOMP(VCOMP), .LRAMSEL(LRAMSEL),
    .LRAMADR(LRAMADR), .LRAMDAT(LRAMDAT), .fill_en(fill_en), .fetch_line(fetch_line),
    .xscroll(xscroll), .hpix(hpix), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .busy(busy), .overrun(overrun), .ovr_cnt(ovr_cnt)
  );

  always #5 gclk = ~gclk;

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pix(input logic [19:0] a);
    return a[15:0] ^ 16'h5A3C ^ {a[19:16], 12'h0};
  endfunction

  function automatic logic [19:0] vaddr(input logic [9:0] line, input logic [9:0] xs, input int i);
    logic [9:0] c;
    c = xs + 10'(i);
    return {line, c};
  endfunction

  task automatic hcomp(input logic sel, input logic en, input logic [9:0] line,
                       input logic [9:0] xs, input logic [10:0] hp);
    LRAMSEL = sel; fill_en = en; fetch_line = line; xscroll = xs; hpix = hp;
    HCOMP = 1'b1;
    tick();
    HCOMP = 1'b0;
  endtask

  task automatic fill_run(input logic half, input logic [9:0] line, input logic [9:0] xs,
                          input int n, input int maxwait, output int busy_cyc);
    logic [19:0] a;
    int w;
    busy_cyc = 0;
    for (int i = 0; i < n; i++) begin
      a = vaddr(line, xs, i);
      w = $urandom_range(maxwait, 0);
      for (int k = 0; k < w; k++) begin
        chk("wait_req", rd_req, 1'b1);
        chk("wait_addr", rd_addr, a);
        if (busy) busy_cyc++;
        tick();
      end
      chk("req", rd_req, 1'b1);
      chk("addr", rd_addr, a);
      if (busy) busy_cyc++;
      rd_ack = 1'b1;
      rd_data = pix(a);
      exp_ram[{half, 10'(i)}] = pix(a);
      tick();
      rd_ack = 1'b0;
    end
    chk("done_req", rd_req, 1'b0);
    chk("done_busy", busy, 1'b0);
  endtask

  task automatic rd_chk(input string tag, input logic half, input logic [9:0] adr);
    LRAMSEL = half;
    LRAMADR = adr;
    tick();
    chk(tag, LRAMDAT, exp_ram[{half, adr}]);
  endtask

  initial begin : main
    logic [19:0] a;
    int bc;
    rst = 1'b1; HCOMP = 0; VCOMP = 0; LRAMSEL = 0; LRAMADR = 0; fill_en = 0;
    fetch_line = 0; xscroll = 0; hpix = 0; rd_ack = 0; rd_data = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_req", rd_req, 1'b0);
    chk("rst_addr", rd_addr, 20'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_cnt", ovr_cnt, 8'd0);
    chk("rst_dat", LRAMDAT, 16'h0);

    // basic fill of half 1, ack every cycle
    hcomp(1'b1, 1'b1, 10'd5, 10'd0, 11'd4);
    chk("t1_addr0", rd_addr, 20'h01400);
    fill_run(1'b1, 10'd5, 10'd0, 4, 0, bc);
    chk("t1_busy_cycles", bc, 4);

    // wait states into half 0
    hcomp(1'b0, 1'b1, 10'd3, 10'd100, 11'd8);
    fill_run(1'b0, 10'd3, 10'd100, 8, 3, bc);

    // horizontal wrap, overwriting x=0..3 of half 0
    hcomp(1'b0, 1'b1, 10'd0, 10'd1022, 11'd4);
    chk("wrap_a0", rd_addr, 20'h003FE);
    fill_run(1'b0, 10'd0, 10'd1022, 4, 1, bc);
    chk("wrap_last", exp_ram[3], pix(20'h00001));

    // ack while idle must not write
    rd_ack = 1'b1; rd_data = 16'hDEAD;
    tick();
    rd_ack = 1'b0;
    chk("idle_ack_busy", busy, 1'b0);
    for (int i = 0; i < 8; i++) rd_chk("rb_h0", 1'b0, 10'(i));
    for (int i = 0; i < 4; i++) rd_chk("rb_h1", 1'b1, 10'(i));

    // fill_en=0 and hpix=0 leave target half untouched
    hcomp(1'b0, 1'b0, 10'd6, 10'd0, 11'd4);
    for (int k = 0; k < 3; k++) begin
      chk("noen_req", rd_req, 1'b0);
      chk("noen_busy", busy, 1'b0);
      tick();
    end
    hcomp(1'b0, 1'b1, 10'd6, 10'd0, 11'd0);
    for (int k = 0; k < 3; k++) begin
      chk("hp0_req", rd_req, 1'b0);
      tick();
    end
    for (int i = 0; i < 8; i++) rd_chk("untouched_h0", 1'b0, 10'(i));

    // display sweep of half 0 while filling half 1
    hcomp(1'b1, 1'b1, 10'd2, 10'd0, 11'd6);
    LRAMSEL = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = vaddr(10'd2, 10'd0, i);
      LRAMADR = 10'(i);
      chk("sw_addr", rd_addr, a);
      rd_ack = 1'b1; rd_data = pix(a);
      exp_ram[{1'b1, 10'(i)}] = pix(a);
      tick();
      chk("sw_dat", LRAMDAT, exp_ram[{1'b0, 10'(i)}]);
    end
    rd_ack = 1'b0;
    chk("sw_busy", busy, 1'b0);
    for (int i = 0; i < 6; i++) rd_chk("rb_sw_h1", 1'b1, 10'(i));

    // overrun: new line start after 2 of 8 acks, with an ack in the same cycle
    hcomp(1'b0, 1'b1, 10'd7, 10'd10, 11'd8);
    for (int i = 0; i < 2; i++) begin
      a = vaddr(10'd7, 10'd10, i);
      chk("ov_addr", rd_addr, a);
      rd_ack = 1'b1; rd_data = pix(a);
      exp_ram[{1'b0, 10'(i)}] = pix(a);
      tick();
    end
    a = vaddr(10'd7, 10'd10, 2);
    chk("ov_addr2", rd_addr, a);
    rd_data = pix(a);
    exp_ram[{1'b0, 10'd2}] = pix(a);
    LRAMSEL = 1'b1; fetch_line = 10'd9; xscroll = 10'd0; hpix = 11'd3; fill_en = 1'b1;
    HCOMP = 1'b1;
    tick();
    HCOMP = 1'b0; rd_ack = 1'b0;
    chk("ov_flag", overrun, 1'b1);
    chk("ov_cnt", ovr_cnt, 8'd1);
    chk("ov_busy", busy, 1'b1);
    chk("ov_restart", rd_addr, 20'h02400);
    fill_run(1'b1, 10'd9, 10'd0, 3, 2, bc);
    VCOMP = 1'b1;
    tick();
    VCOMP = 1'b0;
    chk("vc_cnt", ovr_cnt, 8'd0);
    chk("vc_ovr", overrun, 1'b1);
    for (int i = 0; i < 3; i++) rd_chk("rb_ov_h0", 1'b0, 10'(i));
    for (int i = 0; i < 6; i++) rd_chk("rb_ov_h1", 1'b1, 10'(i));

    // reset mid-fill: partial line kept, no further writes
    hcomp(1'b1, 1'b1, 10'd4, 10'd0, 11'd8);
    for (int i = 0; i < 2; i++) begin
      a = vaddr(10'd4, 10'd0, i);
      chk("rs_addr", rd_addr, a);
      rd_ack = 1'b1; rd_data = pix(a);
      exp_ram[{1'b1, 10'(i)}] = pix(a);
      tick();
    end
    rd_ack = 1'b1; rd_data = 16'hBEEF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_req", rd_req, 1'b0);
    chk("rs_busy", busy, 1'b0);
    chk("rs_ovr", overrun, 1'b0);
    chk("rs_dat", LRAMDAT, 16'h0);
    tick();
    rd_ack = 1'b0;
    for (int i = 0; i < 4; i++) rd_chk("rb_rs_h1", 1'b1, 10'(i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
